// File: rtl/sort_pipe_core.sv
// sort_pipe_core: collects an N-word block from a val/rdy producer, sorts it in
// place with N odd-even transposition passes (one per clock), then streams the
// sorted block to the sort receptor under backpressure. Blocks are handled one
// at a time, in arrival order.
module sort_pipe_core #(
  parameter int DATA_WIDTH = 8,
  parameter int N          = 4,
  parameter bit DESCEND    = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_val,
  output logic                  in_rdy,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  sort_val,
  input  logic                  sort_rdy,
  output logic [DATA_WIDTH-1:0] sort_data,
  output logic                  sort_last,
  output logic                  busy
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_SORT = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;

  logic [1:0]            state;
  logic [CW-1:0]         wr_idx;
  logic [CW-1:0]         pass;
  logic [CW-1:0]         rd_idx;
  logic                  in_rdy_q;
  logic                  accept;
  logic                  xfer;
  logic [DATA_WIDTH-1:0] mem      [N];
  logic [DATA_WIDTH-1:0] mem_pass [N];

  assign accept = in_val & in_rdy_q;
  assign xfer   = (state == ST_SEND) & sort_rdy;

  // One transposition pass: even passes pair (0,1),(2,3)..; odd passes (1,2),(3,4)..
  always_comb begin
    mem_pass = mem;
    for (int unsigned i = 0; i + 1 < N; i++) begin
      if (1'(i) == pass[0]) begin
        if (DESCEND ? (mem[i] < mem[i+1]) : (mem[i] > mem[i+1])) begin
          mem_pass[i]   = mem[i+1];
          mem_pass[i+1] = mem[i];
        end
      end
    end
  end

  // Control: LOAD -> SORT -> SEND sequencing, index counters and registered in_rdy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_LOAD;
      wr_idx   <= '0;
      pass     <= '0;
      rd_idx   <= '0;
      in_rdy_q <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (accept && (wr_idx == LAST)) begin
            state    <= ST_SORT;
            wr_idx   <= '0;
            in_rdy_q <= 1'b0;
          end else begin
            if (accept) begin
              wr_idx <= wr_idx + 1'b1;
            end
            in_rdy_q <= 1'b1;
          end
        end
        ST_SORT: begin
          if (pass == LAST) begin
            state <= ST_SEND;
            pass  <= '0;
          end else begin
            pass <= pass + 1'b1;
          end
        end
        ST_SEND: begin
          if (xfer) begin
            if (rd_idx == LAST) begin
              state    <= ST_LOAD;
              rd_idx   <= '0;
              in_rdy_q <= 1'b1;
            end else begin
              rd_idx <= rd_idx + 1'b1;
            end
          end
        end
        default: begin
          state    <= ST_LOAD;
          in_rdy_q <= 1'b0;
        end
      endcase
    end
  end

  // Block buffer: written word-by-word in LOAD, replaced by each pass in SORT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N; i++) begin
        mem[i] <= '0;
      end
    end else if (state == ST_LOAD) begin
      if (accept) begin
        mem[wr_idx] <= in_data;
      end
    end else if (state == ST_SORT) begin
      mem <= mem_pass;
    end
  end

  assign in_rdy    = in_rdy_q;
  assign busy      = (state == ST_SORT);
  assign sort_val  = (state == ST_SEND);
  assign sort_data = sort_val ? mem[rd_idx] : '0;
  assign sort_last = sort_val & (rd_idx == LAST);

endmodule

// File: tb/tb_sort_pipe_core.sv
// Bench for sort_pipe_core: an ascending N=4 instance and a descending N=6
// instance share one stimulus set; a selector picks whose outputs are checked.
// Expected output of each block is the input block sorted with queue methods.
module tb_sort_pipe_core;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_val;
  logic [7:0] in_data;
  logic       sort_rdy;

  logic       a_in_rdy, a_sort_val, a_sort_last, a_busy;
  logic [7:0] a_sort_data;
  logic       b_in_rdy, b_sort_val, b_sort_last, b_busy;
  logic [7:0] b_sort_data;

  logic       sel;
  logic       m_in_rdy, m_sort_val, m_sort_last, m_busy;
  logic [7:0] m_sort_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sort_pipe_core #(.DATA_WIDTH(8), .N(4), .DESCEND(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_val(in_val), .in_rdy(a_in_rdy), .in_data(in_data),
    .sort_val(a_sort_val), .sort_rdy(sort_rdy), .sort_data(a_sort_data),
    .sort_last(a_sort_last), .busy(a_busy)
  );

  sort_pipe_core #(.DATA_WIDTH(8), .N(6), .DESCEND(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_val(in_val), .in_rdy(b_in_rdy), .in_data(in_data),
    .sort_val(b_sort_val), .sort_rdy(sort_rdy), .sort_data(b_sort_data),
    .sort_last(b_sort_last), .busy(b_busy)
  );

  assign m_in_rdy    = sel ? b_in_rdy    : a_in_rdy;
  assign m_sort_val  = sel ? b_sort_val  : a_sort_val;
  assign m_sort_last = sel ? b_sort_last : a_sort_last;
  assign m_busy      = sel ? b_busy      : a_busy;
  assign m_sort_data = sel ? b_sort_data : a_sort_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Entered just after a negedge; asserts reset, checks async clear, releases.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_in_rdy",    32'(m_in_rdy),    32'd0);
    chk("rst_sort_val",  32'(m_sort_val),  32'd0);
    chk("rst_sort_data", 32'(m_sort_data), 32'd0);
    chk("rst_sort_last", 32'(m_sort_last), 32'd0);
    chk("rst_busy",      32'(m_busy),      32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_rel_in_rdy", 32'(m_in_rdy), 32'd0);
  endtask

  // Feeds one block; returns at the negedge following the last accept edge.
  task automatic do_load(input logic [7:0] w[$], input int gap, input bit rnd);
    int  k   = 0;
    int  cyc = 0;
    bit  acc;
    while (k < w.size() && cyc < 400) begin
      in_val  = rnd ? 1'($urandom_range(0, 1)) : ((cyc % gap) == 0);
      in_data = w[k];
      acc     = in_val && m_in_rdy;
      @(negedge clk);
      if (acc) k++;
      cyc++;
    end
    chk("load_count", 32'(k), 32'(w.size()));
    in_val  = 1'b1;
    in_data = 8'hEE;
  endtask

  // Sort phase then send phase, with in_val held high (must be ignored).
  task automatic do_sort_send(input logic [7:0] w[$], input int bp_idx, input int bp_len,
                              input bit rnd);
    logic [7:0] exp[$];
    int n     = w.size();
    int j     = 0;
    int cyc   = 0;
    int stall = 0;
    bit acc;
    exp = w;
    if (sel) exp.rsort(); else exp.sort();
    for (int c = 0; c < n; c++) begin
      chk("sort_busy",   32'(m_busy),     32'd1);
      chk("sort_val_lo", 32'(m_sort_val), 32'd0);
      chk("sort_in_rdy", 32'(m_in_rdy),   32'd0);
      @(negedge clk);
    end
    chk("busy_fall", 32'(m_busy), 32'd0);
    while (j < n && cyc < 400) begin
      chk("send_val",    32'(m_sort_val),  32'd1);
      chk("send_data",   32'(m_sort_data), 32'(exp[j]));
      chk("send_last",   32'(m_sort_last), 32'(j == n - 1));
      chk("send_in_rdy", 32'(m_in_rdy),    32'd0);
      if (rnd) begin
        sort_rdy = 1'($urandom_range(0, 1));
      end else if (j == bp_idx && stall < bp_len) begin
        sort_rdy = 1'b0;
        stall++;
      end else begin
        sort_rdy = 1'b1;
      end
      acc = sort_rdy && m_sort_val;
      @(negedge clk);
      if (acc) j++;
      cyc++;
    end
    chk("send_count",   32'(j),           32'(n));
    chk("post_val",     32'(m_sort_val),  32'd0);
    chk("post_last",    32'(m_sort_last), 32'd0);
    chk("post_in_rdy",  32'(m_in_rdy),    32'd1);
    sort_rdy = 1'b1;
  endtask

  task automatic run_block(input logic [7:0] w[$], input int gap, input int bp_idx,
                           input int bp_len, input bit rnd);
    do_load(w, gap, rnd);
    do_sort_send(w, bp_idx, bp_len, rnd);
  endtask

  initial begin
    logic [7:0] blk[$];
    rst_n    = 1'b0;
    in_val   = 1'b0;
    in_data  = 8'h00;
    sort_rdy = 1'b1;
    sel      = 1'b0;
    @(negedge clk);
    do_reset();

    // Ascending N=4: basic, duplicates/extremes, back-to-back, backpressure, gaps
    blk = '{8'd4, 8'd3, 8'd2, 8'd1};     run_block(blk, 1, -1, 0, 1'b0);
    blk = '{8'd7, 8'd255, 8'd7, 8'd0};   run_block(blk, 1, -1, 0, 1'b0);
    blk = '{8'd9, 8'd9, 8'd9, 8'd9};     run_block(blk, 1, -1, 0, 1'b0);
    blk = '{8'd10, 8'd30, 8'd20, 8'd40}; run_block(blk, 1, 1, 3, 1'b0);
    blk = '{8'd5, 8'd1, 8'd8, 8'd2};     run_block(blk, 3, -1, 0, 1'b0);
    blk = '{8'd1, 8'd2, 8'd3, 8'd4};     run_block(blk, 1, -1, 0, 1'b0);

    // Reset during pass 2, then a fresh block
    blk = '{8'd3, 8'd1, 8'd2, 8'd0};
    do_load(blk, 1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("mid_sort_busy", 32'(m_busy), 32'd1);
    do_reset();
    blk = '{8'd6, 8'd5, 8'd4, 8'd3};     run_block(blk, 1, -1, 0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      blk = {};
      for (int i = 0; i < 4; i++) blk.push_back(8'($urandom));
      run_block(blk, 1, -1, 0, 1'b1);
    end

    // Descending N=6 instance
    sel = 1'b1;
    @(negedge clk);
    do_reset();
    blk = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6}; run_block(blk, 1, -1, 0, 1'b0);
    blk = '{8'd0, 8'd255, 8'd0, 8'd128, 8'd255, 8'd1}; run_block(blk, 2, 4, 2, 1'b0);
    for (int r = 0; r < 6; r++) begin
      blk = {};
      for (int i = 0; i < 6; i++) blk.push_back(8'($urandom));
      run_block(blk, 1, -1, 0, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sort_pipe_core.md
Name: sort_pipe_core

Overview:
Block sorter that sits directly upstream of the sort receptor and drives its sort_val/sort_rdy/sort_data interface. It collects N words from an upstream val/rdy producer and sorts them in place with N odd-even transposition passes, one pass per clock. It then streams the sorted block downstream, honouring backpressure. Blocks are processed one at a time, in order.

Parameters:
DATA_WIDTH, 8, width of each data word (unsigned)
N, 4, words per block; even, >= 2
DESCEND, 0, 0 = ascending output order, 1 = descending

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous, active-low reset
in_val  input  1  upstream word valid
in_rdy  output  1  block accepts a word
in_data  input  DATA_WIDTH  upstream word
sort_val  output  1  sorted word valid
sort_rdy  input  1  downstream ready
sort_data  output  DATA_WIDTH  sorted word
sort_last  output  1  high with the final word of a block
busy  output  1  high while in SORT

Behaviour:
- Reset: clk is the only clock. rst_n is asynchronous and active-low.
- Reset values: state = LOAD, wr_idx = 0, pass = 0, rd_idx = 0, buffer words = 0. Outputs in_rdy = 0, sort_val = 0, sort_data = 0, sort_last = 0, busy = 0.
- All outputs are registered or decoded from registers. There is no combinational path from in_val/sort_rdy to any output.
- LOAD:
  - in_rdy rises on the first clk edge after rst_n deasserts.
  - Accept occurs when in_val & in_rdy. It writes buf[wr_idx] = in_data and increments wr_idx.
  - in_val is ignored while in_rdy = 0.
  - Gaps in in_val are allowed, with no timeout.
- LOAD -> SORT: on the accept with wr_idx = N-1. in_rdy goes low on that same edge, so no (N+1)th word is accepted. wr_idx clears.
- SORT: busy = 1. There are exactly N passes, one per cycle, with pass = 0..N-1.
  - Even pass: compare pairs (0,1), (2,3), ...
  - Odd pass: compare pairs (1,2), (3,4), ...; words 0 and N-1 are untouched.
  - Swap when buf[i] > buf[i+1] (DESCEND = 0) or buf[i] < buf[i+1] (DESCEND = 1). Comparison is unsigned.
  - Equal values are never swapped.
- SORT -> SEND: after pass N-1. busy falls on the same edge.
- SEND:
  - sort_val = 1, sort_data = buf[rd_idx], sort_last = (rd_idx == N-1).
  - A transfer occurs when sort_val & sort_rdy. On a transfer, rd_idx increments and sort_data updates on the same edge.
  - While sort_val & !sort_rdy, sort_data and sort_last hold stable.
  - sort_val never drops without a transfer.
  - in_rdy = 0 throughout SEND.
- SEND -> LOAD: on the transfer with sort_last = 1. On that edge sort_val falls, sort_last falls, in_rdy rises and rd_idx clears.
- Latency: with the last input accepted at edge E0, sort_val is high after edge E0+N. The first sorted word is visible in the cycle following N sort cycles.
  - Best-case block period with continuous in_val and sort_rdy = 1 is 3N cycles: N load, N sort, N send.
- Reset mid-operation (any state): return to reset values immediately. Any partial or unsent block is discarded, and the next block starts from wr_idx = 0.
- Counter widths are $clog2(N) bits. Index wrap is never used; transitions are explicit at N-1.

Test Plan:
1. Reset, then in_data 4,3,2,1 with in_val continuous and sort_rdy = 1 -> sort_data 1,2,3,4, sort_last only on 4. sort_val first high 4 cycles after the last accept edge. busy high exactly 4 cycles.
2. Block 7,255,7,0 -> 0,7,7,255. A second back-to-back block 9,9,9,9 -> 9,9,9,9. in_rdy is 0 from last accept until the final transfer.
3. Backpressure: block 10,30,20,40 with sort_rdy low for 3 cycles at word 20 -> sort_val stays 1, sort_data stays 20 for those cycles. Output is 10,20,30,40 with no loss or duplication.
4. Upstream gaps: in_val pulsed every 3rd cycle with 5,1,8,2 -> accepted in order, output 1,2,5,8. in_val held high during SORT/SEND -> no extra word accepted.
5. Reset: rst_n asserted during pass 2 of block 3,1,2,0 -> all outputs 0 immediately. The next block 6,5,4,3 -> 3,4,5,6.
6. DESCEND = 1, N = 6: 1,2,3,4,5,6 -> 6,5,4,3,2,1. DESCEND = 0 already-sorted input -> unchanged.
